uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits MSB-first, 1 stop, OVERSAMPLE clk cycles per bit.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around mid-bit instead of a single sample.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int HALF = OVERSAMPLE / 2;

    localparam logic [CW-1:0] SAMPLE_PT = CW'(HALF - 1);
    localparam logic [CW-1:0] DECIDE_PT = CW'(HALF);
    localparam logic [CW-1:0] LAST_PT   = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic          sync_q1, line;
    logic [CW-1:0] os_cnt;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          samp_mid;
    logic          bit_val;
    logic          decide;
    logic          start_det;
    logic          shift_en;
    logic          valid_n;
    logic          err_n;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] EARLY_PT = CW'(HALF - 2);
    logic samp_early;

    // Third vote is the live line value in the decision cycle itself.
    assign bit_val = (samp_early & samp_mid) | (samp_early & line) | (samp_mid & line);

    always_ff @(posedge clk) begin
        if (rst) begin
            samp_early <= 1'b1;
        end else if (os_cnt == EARLY_PT) begin
            samp_early <= line;
        end
    end
`else
    assign bit_val = samp_mid;
`endif

    assign decide = (os_cnt == DECIDE_PT);
    assign busy   = (state != IDLE);

    // Two-flop synchroniser; both preset high so reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            line    <= 1'b1;
        end else begin
            sync_q1 <= din;
            line    <= sync_q1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        case (state)
            IDLE: begin
                if (!line) begin
                    state_n   = START;
                    start_det = 1'b1;
                end
            end
            START: begin
                if (decide) begin
                    state_n = bit_val ? IDLE : DATA;
                end
            end
            DATA: begin
                if (decide) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 4'd8) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop leaves half a bit of idle line to catch the next start.
                if (decide) begin
                    valid_n = bit_val;
                    err_n   = ~bit_val;
                    state_n = bit_val ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (line) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            samp_mid  <= 1'b1;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= valid_n;
            frame_err <= err_n;

            if (start_det) begin
                os_cnt  <= '0;
                bit_cnt <= '0;
            end else if (state == START || state == DATA || state == STOP) begin
                if (os_cnt == LAST_PT) begin
                    os_cnt  <= '0;
                    bit_cnt <= bit_cnt + 4'd1;
                end else begin
                    os_cnt <= os_cnt + 1'b1;
                end
            end

            if (os_cnt == SAMPLE_PT) begin
                samp_mid <= line;
            end

            if (shift_en) begin
                shift_reg <= {shift_reg[6:0], bit_val};
            end

            if (valid_n) begin
                data <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives tx-shaped frames on din and checks strobes, data and timing.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int vcnt = 0, ecnt = 0, both_cnt = 0;
    int last_v = 0, prev_v = 0, last_e = 0;
    logic [7:0] last_dat = 8'h00, prev_dat = 8'h00;
    int t_start = 0;
    int t_prev_start = 0;
    int v0, e0;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            vcnt     <= vcnt + 1;
            prev_v   <= last_v;
            last_v   <= cyc;
            prev_dat <= last_dat;
            last_dat <= data;
        end
        if (frame_err) begin
            ecnt   <= ecnt + 1;
            last_e <= cyc;
        end
        if (valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One 160-cycle frame; abort_at >= 0 pulses rst at that cycle and abandons the frame.
    // spike drops din for one cycle at mid-bit of every high data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int abort_at, input logic spike);
        logic [9:0] bits;
        bits = {1'b0, b, stop_bit};
        for (int c = 0; c < 160; c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                rst = 1'b1;
                din = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                return;
            end
            if (c == 0) t_start = cyc;
            din = bits[9 - c / 16];
            if (spike && (c / 16) >= 1 && (c / 16) <= 8 && (c % 16) == 8 && din)
                din = 1'b0;
        end
    endtask

    initial begin
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(1);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_ferr", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Single clean frame and its latency from the falling din edge
        send_frame(8'hA5, 1'b1, -1, 1'b0);
        wait_cycles(4);
        check("a5_count", vcnt, 1);
        check("a5_data", {24'd0, data}, 32'hA5);
        check("a5_no_err", ecnt, 0);
        check("a5_latency", last_v - t_start, 156);

        // Back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, -1, 1'b0);
        t_prev_start = t_start;
        send_frame(8'hFF, 1'b1, -1, 1'b0);
        wait_cycles(4);
        check("b2b_count", vcnt, 3);
        check("b2b_first", {24'd0, prev_dat}, 32'h00);
        check("b2b_second", {24'd0, last_dat}, 32'hFF);
        check("b2b_spacing", last_v - prev_v, 160);
        check("b2b_gap", t_start - t_prev_start, 160);

        // Short low glitch is rejected at the start-bit decision
        v0 = vcnt;
        e0 = ecnt;
        @(posedge clk);
        #1;
        din = 1'b0;
        wait_cycles(5);
        din = 1'b1;
        check("glitch_busy_mid", {31'd0, busy}, 32'd1);
        wait_cycles(20);
        check("glitch_busy_end", {31'd0, busy}, 32'd0);
        check("glitch_no_valid", vcnt, v0);
        check("glitch_no_err", ecnt, e0);

        // Stop bit low, line held low: frame error then wait for line high
        send_frame(8'h3C, 1'b0, -1, 1'b0);
        wait_cycles(40);
        check("ferr_count", ecnt, e0 + 1);
        check("ferr_latency", last_e - t_start, 156);
        check("ferr_no_valid", vcnt, v0);
        check("ferr_data_hold", {24'd0, data}, 32'hFF);
        check("ferr_busy_wait", {31'd0, busy}, 32'd1);
        din = 1'b1;
        wait_cycles(5);
        check("ferr_busy_release", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b1, -1, 1'b0);
        wait_cycles(4);
        check("after_ferr_count", vcnt, v0 + 1);
        check("after_ferr_data", {24'd0, data}, 32'h5A);

        // Reset during data bit 4 aborts the frame silently
        v0 = vcnt;
        e0 = ecnt;
        send_frame(8'h96, 1'b1, 70, 1'b0);
        check("abort_data", {24'd0, data}, 32'h00);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        check("abort_ferr", {31'd0, frame_err}, 32'd0);
        wait_cycles(200);
        check("abort_no_valid", vcnt, v0);
        check("abort_no_err", ecnt, e0);
        send_frame(8'hC3, 1'b1, -1, 1'b0);
        wait_cycles(4);
        check("c3_count", vcnt, v0 + 1);
        check("c3_data", {24'd0, data}, 32'hC3);

        // Single-cycle mid-bit spikes on every data bit of 0xFF
        send_frame(8'hFF, 1'b1, -1, 1'b1);
        wait_cycles(4);
        check("spike_count", vcnt, v0 + 2);
`ifdef UART_RX_MAJORITY_EN
        check("spike_data", {24'd0, data}, 32'hFF);
`else
        check("spike_data", {24'd0, data}, 32'h00);
`endif

        check("never_both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
